// File: rtl/adc128s_fc_model_if.sv
// adc128s_fc_model_if
//   SPI bus between the balance controller (master) and the ADC128S model
//   (slave).
//   Signals:
//     SS_n - slave select, active low (master -> slave)
//     SCLK - SPI clock, idles high    (master -> slave)
//     MOSI - master-out data          (master -> slave)
//     MISO - slave-out data           (slave -> master)
interface adc128s_fc_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_fc_model.sv
// adc128s_fc_model
//   Model of a National ADC128S 8-channel, 12-bit SPI A2D converter as seen
//   by the Segway balance controller. SPI mode CPOL=1/CPHA=1, 16-bit frames,
//   MSB first. Frame N carries the channel address in bits [13:11]; frame
//   N+1 returns {4'h0, 12-bit value} for that channel.
//   Ports:
//     clk          - system clock, posedge
//     rst_n        - synchronous active-low reset
//     spi          - SPI bus (slave modport): SS_n, SCLK, MOSI in; MISO out
//     ld_cell_lft  - channel 0 value
//     ld_cell_rght - channel 4 value
//     steerPot     - channel 5 value
//     batt         - channel 6 value
//   Parameter:
//     SYNC_STAGES  - synchronizer depth for SS_n/SCLK/MOSI (minimum 2)
//   Optional feature macro: ADC128S_UNUSED_CHNL_ID_EN
//     defined   - channels 1,2,3,7 return 12'hF00 | channel
//     undefined - channels 1,2,3,7 return 12'h000
module adc128s_fc_model #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  adc128s_fc_model_if.slave   spi,
  input  logic [11:0]         ld_cell_lft,
  input  logic [11:0]         ld_cell_rght,
  input  logic [11:0]         steerPot,
  input  logic [11:0]         batt
);

  // Index SYNC_STAGES-1 is the last synchronizer stage; index SYNC_STAGES
  // is the history flop used for edge detection.
  logic [SYNC_STAGES:0] ss_sync_q;
  logic [SYNC_STAGES:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic [15:0] tx_shift_q, tx_shift_d;
  logic [15:0] rx_shift_q, rx_shift_d;
  logic [4:0]  bit_cnt_q,  bit_cnt_d;
  logic [2:0]  chan_q,     chan_d;
  logic        miso_q,     miso_d;

  logic        ss_lvl, ss_fall, ss_rise;
  logic        sclk_rise, sclk_fall;
  logic        mosi_lvl;
  logic [11:0] chan_val;

  assign ss_lvl    = ss_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_sync_q[SYNC_STAGES] & ~ss_lvl;
  assign ss_rise   = ~ss_sync_q[SYNC_STAGES] & ss_lvl;
  assign sclk_rise = ~sclk_sync_q[SYNC_STAGES] & sclk_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_sync_q[SYNC_STAGES] & ~sclk_sync_q[SYNC_STAGES-1];
  assign mosi_lvl  = mosi_sync_q[SYNC_STAGES-1];

  assign spi.MISO = miso_q;

  always_comb begin
    chan_val = '0;
    case (chan_q)
      3'd0:    chan_val = ld_cell_lft;
      3'd4:    chan_val = ld_cell_rght;
      3'd5:    chan_val = steerPot;
      3'd6:    chan_val = batt;
      default: begin
`ifdef ADC128S_UNUSED_CHNL_ID_EN
        chan_val = 12'hF00 | {9'h000, chan_q};
`else
        chan_val = '0;
`endif
      end
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    chan_d     = chan_q;
    miso_d     = miso_q;

    if (ss_fall) begin
      // Analog value is captured here so later input changes cannot
      // corrupt the frame in flight.
      tx_shift_d = {4'h0, chan_val};
      miso_d     = tx_shift_d[15];
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else if (ss_rise) begin
      if (bit_cnt_q == 5'd16)
        chan_d = rx_shift_q[13:11];
    end else if (!ss_lvl) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[14:0], mosi_lvl};
        if (bit_cnt_q != 5'd31)
          bit_cnt_d = bit_cnt_q + 5'd1;
      end
      // The leading SCLK fall precedes the first rise; MSB is already on MISO.
      if (sclk_fall && (bit_cnt_q != 5'd0)) begin
        tx_shift_d = {tx_shift_q[14:0], 1'b0};
        miso_d     = tx_shift_q[14];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '1;
      mosi_sync_q <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      chan_q      <= '0;
      miso_q      <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-1:0], spi.SS_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      bit_cnt_q   <= bit_cnt_d;
      chan_q      <= chan_d;
      miso_q      <= miso_d;
    end
  end

endmodule

// File: tb/tb_adc128s_fc_model.sv
module tb_adc128s_fc_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] ld_cell_lft, ld_cell_rght, steerPot, batt;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: which channel the next full frame reads back.
  logic [2:0] ref_chan;

  adc128s_fc_model_if spi_if ();

  adc128s_fc_model #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi          (spi_if.slave),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_val(input logic [2:0] ch);
    case (ch)
      3'd0:    return ld_cell_lft;
      3'd4:    return ld_cell_rght;
      3'd5:    return steerPot;
      3'd6:    return batt;
`ifdef ADC128S_UNUSED_CHNL_ID_EN
      default: return 12'hF00 + {9'h000, ch};
`else
      default: return 12'h000;
`endif
    endcase
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI transaction with nrises SCLK cycles; SCLK half period = 16 clk.
  // Optionally changes batt once SS_n has been low long enough to be seen.
  task automatic spi_frame(input logic [15:0] mosi_w, input int nrises,
                           input bit chg, input logic [11:0] new_batt,
                           output logic [15:0] miso_w);
    miso_w = '0;
    @(negedge clk);
    spi_if.SS_n = 1'b0;
    wait_clks(16);
    if (chg) batt = new_batt;
    for (int i = 0; i < nrises; i++) begin
      spi_if.SCLK = 1'b0;
      spi_if.MOSI = (i < 16) ? mosi_w[15-i] : 1'b0;
      wait_clks(16);
      if (i < 16) miso_w[15-i] = spi_if.MISO;
      spi_if.SCLK = 1'b1;
      wait_clks(16);
    end
    spi_if.SS_n = 1'b1;
    wait_clks(16);
    if (nrises == 16) ref_chan = mosi_w[13:11];
  endtask

  task automatic test_reset();
    logic [15:0] rx, exp;
    rst_n = 1'b0;
    spi_if.SS_n = 1'b1; spi_if.SCLK = 1'b1; spi_if.MOSI = 1'b0;
    wait_clks(3);
    rst_n = 1'b1;
    ref_chan = 3'd0;
    wait_clks(2);
    n_total++;
    if (spi_if.MISO !== 1'b0) begin
      n_bad++; $display("FAIL reset_miso got=%b exp=0", spi_if.MISO);
    end
    ld_cell_lft = 12'h200;
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h0200) begin
      n_bad++; $display("FAIL first_frame got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_chan4();
    logic [15:0] rx, exp;
    ld_cell_rght = 12'h3A5;
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h2000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp) begin n_bad++; $display("FAIL ch4_req got=%h exp=%h", rx, exp); end
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h03A5) begin
      n_bad++; $display("FAIL ch4_read got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] rx, exp;
    logic [2:0]  chs [5];
    chs = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd0};
    ld_cell_lft = 12'h111; ld_cell_rght = 12'h222; steerPot = 12'h333; batt = 12'hABC;
    foreach (chs[k]) begin
      exp = {4'h0, ref_val(ref_chan)};
      spi_frame({2'b00, chs[k], 11'h000}, 16, 1'b0, 12'h0, rx);
      n_total++;
      if (rx !== exp) begin n_bad++; $display("FAIL round_robin[%0d] got=%h exp=%h", k, rx, exp); end
    end
  endtask

  task automatic test_stability();
    logic [15:0] rx, exp;
    batt = 12'h800;
    spi_frame(16'h3000, 16, 1'b0, 12'h0, rx);
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b1, 12'h123, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h0800) begin
      n_bad++; $display("FAIL batt_stable got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_abort();
    logic [15:0] rx, exp;
    ld_cell_rght = 12'h5C3; steerPot = 12'h0A7;
    spi_frame(16'h2000, 16, 1'b0, 12'h0, rx);
    spi_frame(16'h2800, 8, 1'b0, 12'h0, rx);
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h05C3) begin
      n_bad++; $display("FAIL short_frame got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_excess();
    logic [15:0] rx, exp;
    ld_cell_lft = 12'h7E1; batt = 12'h64D;
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    spi_frame(16'h3000, 18, 1'b0, 12'h0, rx);
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h07E1) begin
      n_bad++; $display("FAIL long_frame got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_unused();
    logic [15:0] rx, exp;
    spi_frame(16'h1000, 16, 1'b0, 12'h0, rx);
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
`ifdef ADC128S_UNUSED_CHNL_ID_EN
    if (rx !== exp || rx !== 16'h0F02) begin
`else
    if (rx !== exp || rx !== 16'h0000) begin
`endif
      n_bad++; $display("FAIL unused_ch2 got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] rx, exp;
    ld_cell_lft = 12'h9D4; batt = 12'h2B6;
    spi_frame(16'h3000, 16, 1'b0, 12'h0, rx);
    @(negedge clk);
    spi_if.SS_n = 1'b0;
    wait_clks(16);
    for (int i = 0; i < 5; i++) begin
      spi_if.SCLK = 1'b0; spi_if.MOSI = 1'b1; wait_clks(16);
      spi_if.SCLK = 1'b1; wait_clks(16);
    end
    rst_n = 1'b0; spi_if.SS_n = 1'b1; spi_if.MOSI = 1'b0;
    wait_clks(2);
    rst_n = 1'b1;
    ref_chan = 3'd0;
    wait_clks(16);
    exp = {4'h0, ref_val(ref_chan)};
    spi_frame(16'h0000, 16, 1'b0, 12'h0, rx);
    n_total++;
    if (rx !== exp || rx !== 16'h09D4) begin
      n_bad++; $display("FAIL reset_mid_frame got=%h exp=%h", rx, exp);
    end
  endtask

  task automatic test_random();
    logic [15:0] rx, exp, mw;
    for (int k = 0; k < 24; k++) begin
      ld_cell_lft  = 12'($urandom);
      ld_cell_rght = 12'($urandom);
      steerPot     = 12'($urandom);
      batt         = 12'($urandom);
      mw = 16'($urandom);
      exp = {4'h0, ref_val(ref_chan)};
      spi_frame(mw, 16, 1'b0, 12'h0, rx);
      n_total++;
      if (rx !== exp) begin n_bad++; $display("FAIL random[%0d] got=%h exp=%h", k, rx, exp); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    spi_if.SS_n = 1'b1; spi_if.SCLK = 1'b1; spi_if.MOSI = 1'b0;
    ld_cell_lft = '0; ld_cell_rght = '0; steerPot = '0; batt = '0;
    ref_chan = 3'd0;
    test_reset();
    test_chan4();
    test_round_robin();
    test_stability();
    test_abort();
    test_excess();
    test_unused();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
